cw305_reg_arbiter: RTL and testbench

- Shares the single CW305 register-block port between two requesters: the host, through the USB register front-end, and an on-chip master, such as a trace/config sequencer.
- The host has absolute priority and is never stalled, because the USB side has no backpressure.
- The internal master is granted single-byte accesses only after the host bus has been idle for a guard window. It is aborted with a retry indication if the host collides with it.
- The block sits between the USB front-end outputs and the project register block.

---
 rtl/cw305_reg_pkg.sv | 17 +
 rtl/cw305_idle_timer.sv | 35 +++
 rtl/cw305_reg_arbiter.sv | 125 ++++++++++++
 tb/tb_cw305_reg_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_reg_pkg.sv
// Shared definitions for the CW305 register-port arbiter: FSM encoding and default bus widths.
package cw305_reg_pkg;

  localparam logic [1:0] ST_HOST_ENC  = 2'd0;
  localparam logic [1:0] ST_M_ACC_ENC = 2'd1;
  localparam logic [1:0] ST_M_FIN_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_HOST  = ST_HOST_ENC,
    ST_M_ACC = ST_M_ACC_ENC,
    ST_M_FIN = ST_M_FIN_ENC
  } state_e;

  localparam int DEF_ADDR_WIDTH   = 21;
  localparam int DEF_BYTECNT_SIZE = 7;

endpackage

// File: rtl/cw305_idle_timer.sv
// Saturating host-idle counter; ready once pGUARD consecutive idle cycles have elapsed.
module cw305_idle_timer #(
  parameter int pGUARD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic act,
  output logic ready
);

  localparam int CW = $clog2(pGUARD + 1);
  localparam logic [CW-1:0] GUARD = CW'(pGUARD);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (act) begin
      cnt_d = '0;
    end else if (cnt_q != GUARD) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ready = (cnt_q == GUARD);

endmodule

// File: rtl/cw305_reg_arbiter.sv
// Shares the CW305 register-block port between the USB host (absolute priority, never
// stalled) and an on-chip master granted single accesses after a host-idle guard window.
module cw305_reg_arbiter
  import cw305_reg_pkg::*;
#(
  parameter int pADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int pBYTECNT_SIZE = DEF_BYTECNT_SIZE,
  parameter int pIDLE_GUARD   = 4
) (
  input  logic                                 usb_clk,
  input  logic                                 rst,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] h_address,
  input  logic [pBYTECNT_SIZE-1:0]             h_bytecnt,
  input  logic [7:0]                           h_datao,
  input  logic                                 h_read,
  input  logic                                 h_write,
  output logic [7:0]                           h_datai,
  input  logic                                 m_req,
  input  logic                                 m_we,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] m_address,
  input  logic [pBYTECNT_SIZE-1:0]             m_bytecnt,
  input  logic [7:0]                           m_wdata,
  output logic                                 m_gnt,
  output logic                                 m_done,
  output logic                                 m_retry,
  output logic [7:0]                           m_rdata,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           reg_datao,
  output logic                                 reg_read,
  output logic                                 reg_write,
  input  logic [7:0]                           reg_datai,
  output logic                                 owner
);

  state_e     state_q, state_d;
  logic       m_retry_q, m_retry_d;
  logic       owner_q, owner_d;
  logic       m_rd_q, m_rd_d;
  logic [7:0] m_rdata_q, m_rdata_d;
  logic       host_act;
  logic       idle_ready;

  assign host_act = h_read | h_write;

  cw305_idle_timer #(
    .pGUARD(pIDLE_GUARD)
  ) u_idle_timer (
    .clk  (usb_clk),
    .rst  (rst),
    .act  (host_act),
    .ready(idle_ready)
  );

  always_comb begin
    state_d     = state_q;
    m_retry_d   = 1'b0;
    m_rd_d      = m_rd_q;
    m_rdata_d   = m_rdata_q;
    m_gnt       = 1'b0;
    m_done      = 1'b0;
    reg_address = h_address;
    reg_bytecnt = h_bytecnt;
    reg_datao   = h_datao;
    reg_read    = h_read;
    reg_write   = h_write;
    // While in reset the host passthrough stays live and no master activity is shown.
    if (!rst) begin
      case (state_q)
        ST_HOST: begin
          if (m_req && idle_ready && !host_act) begin
            state_d = ST_M_ACC;
          end
        end
        ST_M_ACC: begin
          if (host_act) begin
            state_d   = ST_HOST;
            m_retry_d = 1'b1;
          end else begin
            m_gnt       = 1'b1;
            reg_address = m_address;
            reg_bytecnt = m_bytecnt;
            reg_datao   = m_wdata;
            reg_read    = ~m_we;
            reg_write   = m_we;
            m_rd_d      = ~m_we;
            state_d     = ST_M_FIN;
          end
        end
        ST_M_FIN: begin
          m_done  = 1'b1;
          state_d = ST_HOST;
          // Read data arrives this cycle; bypass it so m_rdata is valid alongside m_done.
          if (m_rd_q) begin
            m_rdata_d = reg_datai;
          end
        end
        default: state_d = ST_HOST;
      endcase
    end
    owner_d = (state_d == ST_M_ACC);
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      state_q   <= ST_HOST;
      m_retry_q <= 1'b0;
      owner_q   <= 1'b0;
      m_rd_q    <= 1'b0;
      m_rdata_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      m_retry_q <= m_retry_d;
      owner_q   <= owner_d;
      m_rd_q    <= m_rd_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_retry = m_retry_q;
  assign owner   = owner_q;
  assign m_rdata = m_rdata_d;
  assign h_datai = reg_datai;

endmodule

// File: tb/tb_cw305_reg_arbiter.sv
// Self-checking bench for cw305_reg_arbiter: host passthrough vector table, master
// transactions scored through a completion queue, guard-window, collision and reset cases.
module tb_cw305_reg_arbiter;

  localparam int AW = 14;
  localparam int BW = 7;
  localparam int GUARD = 4;

  logic          usb_clk;
  logic          rst;
  logic [AW-1:0] h_address;
  logic [BW-1:0] h_bytecnt;
  logic [7:0]    h_datao;
  logic          h_read, h_write;
  logic [7:0]    h_datai;
  logic          m_req, m_we;
  logic [AW-1:0] m_address;
  logic [BW-1:0] m_bytecnt;
  logic [7:0]    m_wdata;
  logic          m_gnt, m_done, m_retry;
  logic [7:0]    m_rdata;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    reg_datao;
  logic          reg_read, reg_write;
  logic [7:0]    reg_datai;
  logic          owner;

  cw305_reg_arbiter #(
    .pADDR_WIDTH  (21),
    .pBYTECNT_SIZE(7),
    .pIDLE_GUARD  (GUARD)
  ) dut (
    .usb_clk    (usb_clk),
    .rst        (rst),
    .h_address  (h_address),
    .h_bytecnt  (h_bytecnt),
    .h_datao    (h_datao),
    .h_read     (h_read),
    .h_write    (h_write),
    .h_datai    (h_datai),
    .m_req      (m_req),
    .m_we       (m_we),
    .m_address  (m_address),
    .m_bytecnt  (m_bytecnt),
    .m_wdata    (m_wdata),
    .m_gnt      (m_gnt),
    .m_done     (m_done),
    .m_retry    (m_retry),
    .m_rdata    (m_rdata),
    .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt),
    .reg_datao  (reg_datao),
    .reg_read   (reg_read),
    .reg_write  (reg_write),
    .reg_datai  (reg_datai),
    .owner      (owner)
  );

  initial begin
    usb_clk = 1'b0;
    forever #5 usb_clk = ~usb_clk;
  end

  // Register block model: writes land at the edge, read data returns one cycle after reg_read.
  logic [7:0] mem [0:255];
  always @(posedge usb_clk) begin
    if (reg_write) mem[reg_address[7:0]] <= reg_datao;
    reg_datai <= reg_read ? mem[reg_address[7:0]] : 8'h00;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         retry;
    logic       we;
    logic [7:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  // Every completion or retry pulse must match the oldest expectation.
  always @(negedge usb_clk) begin
    if (m_done || m_retry) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_event", {30'd0, m_done, m_retry}, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_kind", {30'd0, m_done, m_retry}, e.retry ? 32'd1 : 32'd2);
        if (!e.retry && !e.we) chk("sb_rdata", {24'd0, m_rdata}, {24'd0, e.rdata});
        $display("[TB] master %s done=%0d retry=%0d rdata=0x%02h", e.we ? "wr" : "rd",
                 m_done, m_retry, m_rdata);
      end
    end
  end

  task automatic nxt();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge usb_clk);
  endtask

  task automatic host_idle();
    h_read  = 1'b0;
    h_write = 1'b0;
  endtask

  task automatic idle(input int n);
    host_idle();
    repeat (n) nxt();
  endtask

  task automatic master_txn(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                            input logic [7:0] exp_rd);
    int n;
    m_req = 1'b1; m_we = we; m_address = addr; m_bytecnt = 7'd1; m_wdata = wd;
    sb_q.push_back('{retry: 1'b0, we: we, rdata: exp_rd});
    n = 0;
    smp();
    while (!m_gnt && n < 40) begin
      nxt();
      smp();
      n++;
    end
    chk("mtxn_gnt_seen", {31'd0, m_gnt}, 32'd1);
    if (m_gnt) begin
      chk("mtxn_reg_write", {31'd0, reg_write}, {31'd0, we});
      chk("mtxn_reg_read", {31'd0, reg_read}, {31'd0, ~we});
      chk("mtxn_reg_address", {18'd0, reg_address}, {18'd0, addr});
      chk("mtxn_reg_bytecnt", {25'd0, reg_bytecnt}, 32'd1);
      if (we) chk("mtxn_reg_datao", {24'd0, reg_datao}, {24'd0, wd});
      chk("mtxn_owner_acc", {31'd0, owner}, 32'd1);
      nxt();
      smp();
      chk("mtxn_done", {31'd0, m_done}, 32'd1);
      chk("mtxn_gnt_fin", {31'd0, m_gnt}, 32'd0);
      chk("mtxn_owner_fin", {31'd0, owner}, 32'd0);
    end
    nxt();
    m_req = 1'b0;
  endtask

  // Host access at k=0 (plus optional write at k=3) with m_req already high; returns grant cycle.
  task automatic guard_seq(input bit restart, input int exp_k, input logic we,
                           input logic [AW-1:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
    int gk;
    gk = -1;
    m_req = 1'b1; m_we = we; m_address = addr; m_bytecnt = 7'd1; m_wdata = wd;
    sb_q.push_back('{retry: 1'b0, we: we, rdata: exp_rd});
    h_address = 14'h20; h_bytecnt = 7'd1; h_datao = 8'h99;
    for (int k = 0; k < 16; k++) begin
      h_read  = (k == 0);
      h_write = restart && (k == 3);
      smp();
      if (m_gnt) begin
        gk = k;
        break;
      end
      nxt();
    end
    host_idle();
    chk(restart ? "guard_restart_grant_cycle" : "guard_grant_cycle", gk, exp_k);
    if (gk >= 0) begin
      nxt();
      smp();
      chk("guard_done", {31'd0, m_done}, 32'd1);
    end
    nxt();
    m_req = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [7:0]    d;
    logic          rd;
    logic          wr;
    logic          mreq;
    logic [AW-1:0] exp_addr;
    logic [BW-1:0] exp_bc;
    logic [7:0]    exp_do;
    logic          exp_rd;
    logic          exp_wr;
    bit            chk_hdi;
    logic [7:0]    exp_hdi;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h77;

    //        addr     bc     d      rd    wr    mreq  exp_addr exp_bc exp_do rd    wr    chk   hdi
    vecs[0] = '{14'h05,  7'd3,  8'hA5, 1'b0, 1'b1, 1'b0, 14'h05,  7'd3,  8'hA5, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{14'h05,  7'd1,  8'h00, 1'b1, 1'b0, 1'b1, 14'h05,  7'd1,  8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2] = '{14'h05,  7'd1,  8'h00, 1'b0, 1'b0, 1'b0, 14'h05,  7'd1,  8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[3] = '{14'h12,  7'd0,  8'hFF, 1'b0, 1'b1, 1'b1, 14'h12,  7'd0,  8'hFF, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[4] = '{14'h12,  7'd2,  8'h00, 1'b1, 1'b0, 1'b0, 14'h12,  7'd2,  8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{14'h3FFF, 7'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 14'h3FFF, 7'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF};
    vecs[6] = '{14'h3FFF, 7'h7F, 8'h81, 1'b0, 1'b1, 1'b1, 14'h3FFF, 7'h7F, 8'h81, 1'b0, 1'b1, 1'b0, 8'h00};

    // Reset, with a host write presented to show passthrough is live during reset.
    rst = 1'b1;
    m_req = 1'b0; m_we = 1'b0; m_address = '0; m_bytecnt = '0; m_wdata = '0;
    h_address = 14'h33; h_bytecnt = 7'd2; h_datao = 8'h44; h_read = 1'b0; h_write = 1'b1;
    repeat (3) nxt();
    smp();
    chk("rst_m_outputs", {28'd0, m_gnt, m_done, m_retry, owner}, 32'd0);
    chk("rst_m_rdata", {24'd0, m_rdata}, 32'd0);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd1);
    chk("rst_reg_address", {18'd0, reg_address}, 32'h33);
    chk("rst_reg_datao", {24'd0, reg_datao}, 32'h44);
    $display("[TB] reset: reg_write=%0d reg_address=0x%0h owner=%0d", reg_write, reg_address, owner);
    nxt();
    rst = 1'b0;
    host_idle();

    // Host-only vectors: reg_* must mirror h_*, master outputs stay quiet.
    for (int i = 0; i < 7; i++) begin
      h_address = vecs[i].addr; h_bytecnt = vecs[i].bc; h_datao = vecs[i].d;
      h_read = vecs[i].rd; h_write = vecs[i].wr; m_req = vecs[i].mreq;
      m_we = 1'b1; m_address = 14'h2A; m_bytecnt = 7'd5; m_wdata = 8'hC3;
      smp();
      chk("vec_reg_address", {18'd0, reg_address}, {18'd0, vecs[i].exp_addr});
      chk("vec_reg_bytecnt", {25'd0, reg_bytecnt}, {25'd0, vecs[i].exp_bc});
      chk("vec_reg_datao", {24'd0, reg_datao}, {24'd0, vecs[i].exp_do});
      chk("vec_reg_strobes", {30'd0, reg_read, reg_write}, {30'd0, vecs[i].exp_rd, vecs[i].exp_wr});
      chk("vec_m_quiet", {28'd0, m_gnt, m_done, m_retry, owner}, 32'd0);
      if (vecs[i].chk_hdi) chk("vec_h_datai", {24'd0, h_datai}, {24'd0, vecs[i].exp_hdi});
      $display("[TB] host vec %0d: addr=0x%0h rd=%0d wr=%0d h_datai=0x%02h", i, reg_address,
               reg_read, reg_write, h_datai);
      nxt();
    end
    m_req = 1'b0;
    host_idle();

    // Master write, then reads (back-to-back allowed while host stays idle).
    idle(6);
    master_txn(1'b1, 14'h02, 8'h3C, 8'h00);
    idle(1);
    master_txn(1'b0, 14'h01, 8'h00, 8'h77);
    idle(3);
    smp();
    chk("rdata_held", {24'd0, m_rdata}, 32'h77);
    nxt();
    master_txn(1'b0, 14'h02, 8'h00, 8'h3C);

    // Guard window, plain and with a host write restarting the count.
    idle(2);
    guard_seq(1'b0, GUARD + 2, 1'b1, 14'h04, 8'h11, 8'h00);
    idle(2);
    guard_seq(1'b1, GUARD + 5, 1'b0, 14'h04, 8'h00, 8'h11);

    // Collision: host write lands in the M_ACC cycle.
    idle(6);
    m_req = 1'b1; m_we = 1'b1; m_address = 14'h03; m_bytecnt = 7'd1; m_wdata = 8'hEE;
    sb_q.push_back('{retry: 1'b1, we: 1'b1, rdata: 8'h00});
    smp();
    chk("coll_pre_gnt", {31'd0, m_gnt}, 32'd0);
    nxt();
    h_write = 1'b1; h_address = 14'h07; h_bytecnt = 7'd2; h_datao = 8'h5A;
    smp();
    chk("coll_reg_write", {30'd0, reg_read, reg_write}, 32'd1);
    chk("coll_reg_address", {18'd0, reg_address}, 32'h07);
    chk("coll_reg_datao", {24'd0, reg_datao}, 32'h5A);
    chk("coll_m_gnt", {31'd0, m_gnt}, 32'd0);
    nxt();
    host_idle();
    smp();
    chk("coll_retry_pulse", {31'd0, m_retry}, 32'd1);
    chk("coll_no_done", {31'd0, m_done}, 32'd0);
    nxt();
    smp();
    chk("coll_retry_one_cycle", {31'd0, m_retry}, 32'd0);
    nxt();
    master_txn(1'b1, 14'h03, 8'hEE, 8'h00);
    idle(1);
    master_txn(1'b0, 14'h03, 8'h00, 8'hEE);

    // Reset asserted during M_ACC: access dropped silently.
    idle(6);
    m_req = 1'b1; m_we = 1'b0; m_address = 14'h01; m_bytecnt = 7'd1;
    nxt();
    smp();
    chk("rstmid_in_acc_owner", {31'd0, owner}, 32'd1);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    m_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("rstmid_no_done_retry", {30'd0, m_done, m_retry}, 32'd0);
      chk("rstmid_owner", {31'd0, owner}, 32'd0);
      chk("rstmid_m_rdata", {24'd0, m_rdata}, 32'd0);
      nxt();
    end
    h_read = 1'b1; h_address = 14'h15; h_bytecnt = 7'd1;
    smp();
    chk("rstmid_host_passthrough", {30'd0, reg_read, reg_write}, 32'd2);
    chk("rstmid_host_address", {18'd0, reg_address}, 32'h15);
    $display("[TB] reset mid-access: owner=%0d m_rdata=0x%02h", owner, m_rdata);
    nxt();
    host_idle();
    idle(2);

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
